// File: rtl/dct_block_sequencer.sv
// dct_block_sequencer
//
// Walks the 64 output coefficients of an 8x8 2-D DCT in raster order
// (k1 outer, k2 inner). For each coefficient it sweeps the 64 pixel/LUT
// addresses, multiply-accumulates level-shifted pixels against the cosine
// term from the LUT bank, then rounds, shifts and saturates the sum. It
// presents the result on a valid/ready stream.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin transforming the block in the pixel buffer (IDLE only)
//   busy              high while a block is being processed
//   lut_k1, lut_k2    coefficient index driven to the cosine LUT bank
//   n1, n2            pixel row/column address (also the LUT n inputs)
//   cos_term          combinational LUT output for the current address
//   pix_rdata         pixel read data, one cycle behind n1/n2
//   coef_valid/ready  output coefficient handshake
//   coef_data         signed, rounded and saturated coefficient
//   coef_k1, coef_k2  index of coef_data
//   done              one-cycle pulse after the 64th coefficient handshake
module dct_block_sequencer #(
    parameter int PIX_W        = 8,
    parameter int COS_W        = 32,
    parameter int ACC_W        = 32,
    parameter int RESULT_SHIFT = 10,
    parameter int COEF_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [2:0]        lut_k1,
    output logic [2:0]        lut_k2,
    output logic [2:0]        n1,
    output logic [2:0]        n2,
    input  logic [COS_W-1:0]  cos_term,
    input  logic [PIX_W-1:0]  pix_rdata,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_data,
    output logic [2:0]        coef_k1,
    output logic [2:0]        coef_k2,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic signed [PIX_W:0] PIX_OFFSET =
        {2'b01, {(PIX_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] ROUND_BIAS =
        {{(ACC_W+1-RESULT_SHIFT){1'b0}}, 1'b1, {(RESULT_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_W:0] COEF_MAX_EXT =
        {{(ACC_W+1-COEF_W){1'b0}}, 1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] COEF_MIN_EXT =
        {{(ACC_W+1-COEF_W){1'b1}}, 1'b1, {(COEF_W-1){1'b0}}};

    state_t state, state_nx;

    logic [5:0]               k_cnt;
    logic [5:0]               n_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [COS_W-1:0]  cos_q;

    logic signed [PIX_W:0]    pix_shift;
    logic signed [ACC_W-1:0]  pix_ext;
    logic signed [ACC_W-1:0]  cos_ext;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    shifted_full;
    logic [COEF_W-1:0]        sat_val;

    assign lut_k1 = k_cnt[5:3];
    assign lut_k2 = k_cnt[2:0];
    assign n1     = n_cnt[5:3];
    assign n2     = n_cnt[2:0];

    // Datapath arithmetic. The pixel and cosine term are both brought to
    // ACC_W bits before multiplying, so the product is the low ACC_W bits of
    // the full product. Rounding is done one bit wider than the accumulator
    // so that adding the half-LSB bias can never wrap.
    always_comb begin
        pix_shift    = $signed({1'b0, pix_rdata}) - PIX_OFFSET;
        pix_ext      = ACC_W'(pix_shift);
        cos_ext      = ACC_W'(cos_q);
        prod         = pix_ext * cos_ext;
        acc_sum      = acc + prod;
        rnd_sum      = $signed({acc_sum[ACC_W-1], acc_sum}) + ROUND_BIAS;
        shifted_full = rnd_sum >>> RESULT_SHIFT;
        if (shifted_full > COEF_MAX_EXT) begin
            sat_val = {1'b0, {(COEF_W-1){1'b1}}};
        end else if (shifted_full < COEF_MIN_EXT) begin
            sat_val = {1'b1, {(COEF_W-1){1'b0}}};
        end else begin
            sat_val = shifted_full[COEF_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = (state != S_IDLE);
        coef_valid = (state == S_OUT);
        case (state)
            S_IDLE:  if (start) state_nx = S_MAC;
            S_MAC:   if (n_cnt == 6'd63) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_OUT;
            S_OUT: begin
                if (coef_ready) begin
                    state_nx = (k_cnt == 6'd63) ? S_IDLE : S_MAC;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Counters, accumulator and output registers. In MAC the pixel and the
    // registered cosine term both refer to the previous address, so the
    // first MAC cycle only primes cos_q and DRAIN adds the n=63 product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt     <= '0;
            n_cnt     <= '0;
            acc       <= '0;
            cos_q     <= '0;
            coef_data <= '0;
            coef_k1   <= '0;
            coef_k2   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_cnt <= '0;
                        n_cnt <= '0;
                        acc   <= '0;
                    end
                end
                S_MAC: begin
                    cos_q <= $signed(cos_term);
                    if (n_cnt != 6'd0) begin
                        acc <= acc_sum;
                    end
                    if (n_cnt != 6'd63) begin
                        n_cnt <= n_cnt + 6'd1;
                    end
                end
                S_DRAIN: begin
                    acc       <= acc_sum;
                    coef_data <= sat_val;
                    coef_k1   <= k_cnt[5:3];
                    coef_k2   <= k_cnt[2:0];
                end
                S_OUT: begin
                    if (coef_ready) begin
                        acc   <= '0;
                        n_cnt <= '0;
                        if (k_cnt == 6'd63) begin
                            done  <= 1'b1;
                            k_cnt <= '0;
                        end else begin
                            k_cnt <= k_cnt + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_block_sequencer.sv
// tb_dct_block_sequencer
//
// Self-checking bench for dct_block_sequencer. It models the pixel buffer
// (one-cycle read latency) and the cosine LUT bank (combinational), and
// checks every coefficient against the direct sum over the 64 pixels.
module tb_dct_block_sequencer;

    localparam int PIX_W  = 8;
    localparam int COS_W  = 32;
    localparam int COEF_W = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic [2:0]        lut_k1;
    logic [2:0]        lut_k2;
    logic [2:0]        n1;
    logic [2:0]        n2;
    logic [COS_W-1:0]  cos_term;
    logic [PIX_W-1:0]  pix_rdata;
    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_data;
    logic [2:0]        coef_k1;
    logic [2:0]        coef_k2;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;

    int         lut [64][64];
    logic [7:0] pix [64];

    logic [15:0] got_data [64];
    logic [5:0]  got_k [64];
    int          valid_cyc [64];
    int          hs_cyc [64];
    bit          stall_changed [64];
    int          nhs;
    int          done_cyc;
    int          done_count;
    bit          timeout;

    dct_block_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .lut_k1     (lut_k1),
        .lut_k2     (lut_k2),
        .n1         (n1),
        .n2         (n2),
        .cos_term   (cos_term),
        .pix_rdata  (pix_rdata),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .coef_k1    (coef_k1),
        .coef_k2    (coef_k2),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cos_term = lut[{lut_k1, lut_k2}][{n1, n2}];

    always @(posedge clk) pix_rdata <= pix[{n1, n2}];

    // Reference: direct 64-term sum with 32-bit wrapping, round half up,
    // arithmetic shift by 10, clamp to 16-bit signed.
    function automatic int model_coef(int k);
        int     acc;
        longint t;
        acc = 0;
        for (int n = 0; n < 64; n++) begin
            acc += (int'(pix[n]) - 128) * lut[k][n];
        end
        t = (longint'(acc) + 64'sd512) >>> 10;
        if (t > 32767) t = 32767;
        else if (t < -32768) t = -32768;
        return int'(t);
    endfunction

    // Q.8 DCT basis including C(k1)C(k2); values within 1e-6 of an integer
    // snap to it, everything else truncates toward zero.
    function automatic void build_dct_lut();
        real pi, c1, c2, r, rr;
        pi = 3.14159265358979323846;
        for (int k = 0; k < 64; k++) begin
            for (int n = 0; n < 64; n++) begin
                int k1v, k2v, n1v, n2v;
                k1v = k / 8; k2v = k % 8; n1v = n / 8; n2v = n % 8;
                c1 = (k1v == 0) ? 0.7071067811865476 : 1.0;
                c2 = (k2v == 0) ? 0.7071067811865476 : 1.0;
                r  = 256.0 * c1 * c2
                   * $cos(real'((2 * n1v + 1) * k1v) * pi / 16.0)
                   * $cos(real'((2 * n2v + 1) * k2v) * pi / 16.0);
                rr = (r >= 0.0) ? $floor(r + 0.5) : -$floor(-r + 0.5);
                if ((r - rr) < 1e-6 && (rr - r) < 1e-6) lut[k][n] = $rtoi(rr);
                else lut[k][n] = $rtoi(r);
            end
        end
    endfunction

    function automatic void build_random_lut();
        for (int k = 0; k < 64; k++) begin
            for (int n = 0; n < 64; n++) begin
                lut[k][n] = int'($urandom_range(65535)) - 32768;
            end
        end
    endfunction

    function automatic void random_pixels();
        for (int n = 0; n < 64; n++) pix[n] = 8'($urandom_range(255));
    endfunction

    // Starts a block (start high in cycle 0) and records ncoef handshakes.
    // Cycle c is sampled at the negedge after c rising edges. Coefficient
    // stalls come from stall_idx/stall_len or, if rnd, 0..3 random cycles;
    // pulse_idx >= 0 pulses start once while coefficient pulse_idx is in MAC.
    task automatic run_block(input int ncoef, input int stall_idx,
                             input int stall_len, input bit rnd,
                             input int pulse_idx);
        int          c;
        int          stall;
        bit          seen;
        bit          pulsed;
        logic [15:0] held_d;
        logic [5:0]  held_n;
        logic [5:0]  held_k;
        c = 0; stall = 0; seen = 0; pulsed = 0;
        held_d = '0; held_n = '0; held_k = '0;
        nhs = 0; done_cyc = -1; done_count = 0; timeout = 0;
        for (int i = 0; i < 64; i++) begin
            stall_changed[i] = 0; valid_cyc[i] = -1; hs_cyc[i] = -1;
        end
        @(negedge clk);
        coef_ready = 1'b1;
        start = 1'b1;
        while (1) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (pulse_idx >= 0 && nhs == pulse_idx && !pulsed && !coef_valid && c > 2) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (coef_valid && nhs < 64) begin
                if (!seen) begin
                    seen = 1;
                    valid_cyc[nhs] = c;
                    held_d = coef_data;
                    held_n = {n1, n2};
                    held_k = {coef_k1, coef_k2};
                    if (rnd) stall = int'($urandom_range(3));
                    else if (nhs == stall_idx) stall = stall_len;
                    else stall = 0;
                end else if (coef_data !== held_d || {n1, n2} !== held_n ||
                             {coef_k1, coef_k2} !== held_k) begin
                    stall_changed[nhs] = 1;
                end
                if (stall > 0) begin
                    coef_ready = 1'b0;
                    stall--;
                end else begin
                    coef_ready = 1'b1;
                    got_data[nhs] = coef_data;
                    got_k[nhs] = {coef_k1, coef_k2};
                    hs_cyc[nhs] = c;
                    nhs++;
                    seen = 0;
                end
            end else begin
                coef_ready = 1'b1;
                if (seen && nhs < 64) stall_changed[nhs] = 1;
            end
            if (nhs == ncoef && ncoef < 64) break;
            if (nhs == 64 && c >= hs_cyc[63] + 3) break;
            if (c > 20000) begin
                timeout = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; coef_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, coef_valid, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000", {busy, coef_valid, done});
        end
        vectors++;
        if (coef_data !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 0000", coef_data);
        end
        vectors++;
        if ({lut_k1, lut_k2, n1, n2, coef_k1, coef_k2} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_idx: got %h expected 0",
                     {lut_k1, lut_k2, n1, n2, coef_k1, coef_k2});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_no_start: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_flat_128();
        int exp;
        build_dct_lut();
        for (int n = 0; n < 64; n++) pix[n] = 8'd128;
        run_block(64, -1, 0, 0, -1);
        vectors++;
        if (timeout) begin
            miscompares++;
            $display("[TB] FAIL flat128_timeout: got %0d coefs expected 64", nhs);
        end
        for (int j = 0; j < 64; j++) begin
            exp = model_coef(j);
            vectors++;
            if (int'($signed(got_data[j])) !== exp || got_k[j] !== 6'(j)) begin
                miscompares++;
                $display("[TB] FAIL flat128_coef%0d: got %0d @k%0d expected %0d @k%0d",
                         j, $signed(got_data[j]), got_k[j], exp, j);
            end
            vectors++;
            if (valid_cyc[j] !== 66 + 66 * j) begin
                miscompares++;
                $display("[TB] FAIL flat128_latency%0d: got cycle %0d expected %0d",
                         j, valid_cyc[j], 66 + 66 * j);
            end
        end
        vectors++;
        if (done_cyc !== 4225 || done_count !== 1) begin
            miscompares++;
            $display("[TB] FAIL flat128_done: got cycle %0d x%0d expected 4225 x1",
                     done_cyc, done_count);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flat128_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_flat_255();
        int exp;
        for (int n = 0; n < 64; n++) pix[n] = 8'd255;
        run_block(64, -1, 0, 0, -1);
        vectors++;
        if (timeout || int'($signed(got_data[0])) !== 1016) begin
            miscompares++;
            $display("[TB] FAIL flat255_dc: got %0d expected 1016", $signed(got_data[0]));
        end
        for (int j = 1; j < 64; j++) begin
            exp = model_coef(j);
            vectors++;
            if (int'($signed(got_data[j])) !== exp || got_k[j] !== 6'(j)) begin
                miscompares++;
                $display("[TB] FAIL flat255_coef%0d: got %0d expected %0d",
                         j, $signed(got_data[j]), exp);
            end
        end
    endtask

    task automatic test_impulse();
        int exp;
        for (int n = 0; n < 64; n++) pix[n] = 8'd128;
        pix[0] = 8'd255;
        run_block(64, -1, 0, 0, -1);
        vectors++;
        if (timeout || int'($signed(got_data[11])) !== 26 || got_k[11] !== 6'o13) begin
            miscompares++;
            $display("[TB] FAIL impulse_k13: got %0d expected 26", $signed(got_data[11]));
        end
        for (int j = 0; j < 64; j++) begin
            exp = model_coef(j);
            vectors++;
            if (int'($signed(got_data[j])) !== exp) begin
                miscompares++;
                $display("[TB] FAIL impulse_coef%0d: got %0d expected %0d",
                         j, $signed(got_data[j]), exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp;
        random_pixels();
        run_block(64, 0, 5, 0, -1);
        vectors++;
        if (timeout || valid_cyc[0] !== 66 || hs_cyc[0] !== 71) begin
            miscompares++;
            $display("[TB] FAIL bp_hs0: got valid %0d hs %0d expected 66 71",
                     valid_cyc[0], hs_cyc[0]);
        end
        vectors++;
        if (stall_changed[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_stable: got changed=%b expected 0", stall_changed[0]);
        end
        vectors++;
        if (valid_cyc[1] - hs_cyc[0] !== 66) begin
            miscompares++;
            $display("[TB] FAIL bp_next: got gap %0d expected 66", valid_cyc[1] - hs_cyc[0]);
        end
        for (int j = 0; j < 64; j++) begin
            exp = model_coef(j);
            vectors++;
            if (int'($signed(got_data[j])) !== exp || got_k[j] !== 6'(j)) begin
                miscompares++;
                $display("[TB] FAIL bp_coef%0d: got %0d expected %0d",
                         j, $signed(got_data[j]), exp);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int exp;
        random_pixels();
        run_block(64, -1, 0, 0, 3);
        vectors++;
        if (timeout || done_count !== 1 || done_cyc !== 4225) begin
            miscompares++;
            $display("[TB] FAIL swb_done: got cycle %0d x%0d expected 4225 x1",
                     done_cyc, done_count);
        end
        for (int j = 0; j < 64; j++) begin
            exp = model_coef(j);
            vectors++;
            if (int'($signed(got_data[j])) !== exp || got_k[j] !== 6'(j) ||
                valid_cyc[j] !== 66 + 66 * j) begin
                miscompares++;
                $display("[TB] FAIL swb_coef%0d: got %0d @cyc%0d expected %0d @cyc%0d",
                         j, $signed(got_data[j]), valid_cyc[j], exp, 66 + 66 * j);
            end
        end
    endtask

    task automatic test_reset_midblock();
        int exp;
        random_pixels();
        run_block(10, -1, 0, 0, -1);
        vectors++;
        if (timeout || nhs !== 10) begin
            miscompares++;
            $display("[TB] FAIL rstmid_pre: got %0d coefs expected 10", nhs);
        end
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, coef_valid, done, coef_data, lut_k1, lut_k2, n1, n2, coef_k1, coef_k2} !== 37'h0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_async: got %h expected 0",
                     {busy, coef_valid, done, coef_data, lut_k1, lut_k2, n1, n2, coef_k1, coef_k2});
        end
        @(negedge clk);
        rst = 1'b0;
        random_pixels();
        run_block(64, -1, 0, 0, -1);
        vectors++;
        if (timeout || valid_cyc[0] !== 66 || done_cyc !== 4225) begin
            miscompares++;
            $display("[TB] FAIL rstmid_restart: got first %0d done %0d expected 66 4225",
                     valid_cyc[0], done_cyc);
        end
        for (int j = 0; j < 64; j++) begin
            exp = model_coef(j);
            vectors++;
            if (int'($signed(got_data[j])) !== exp || got_k[j] !== 6'(j)) begin
                miscompares++;
                $display("[TB] FAIL rstmid_coef%0d: got %0d expected %0d",
                         j, $signed(got_data[j]), exp);
            end
        end
    endtask

    task automatic test_saturation_random();
        int exp;
        int nsat;
        build_random_lut();
        random_pixels();
        run_block(64, -1, 0, 1, -1);
        nsat = 0;
        vectors++;
        if (timeout || done_count !== 1) begin
            miscompares++;
            $display("[TB] FAIL sat_done: got %0d coefs done x%0d expected 64 x1",
                     nhs, done_count);
        end
        for (int j = 0; j < 64; j++) begin
            exp = model_coef(j);
            if (exp == 32767 || exp == -32768) nsat++;
            vectors++;
            if (int'($signed(got_data[j])) !== exp || got_k[j] !== 6'(j) ||
                stall_changed[j] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL sat_coef%0d: got %0d chg=%b expected %0d chg=0",
                         j, $signed(got_data[j]), stall_changed[j], exp);
            end
            if (j < 63) begin
                vectors++;
                if (valid_cyc[j + 1] - hs_cyc[j] !== 66) begin
                    miscompares++;
                    $display("[TB] FAIL sat_gap%0d: got %0d expected 66",
                             j, valid_cyc[j + 1] - hs_cyc[j]);
                end
            end
        end
        $display("[TB] random LUT block: %0d of 64 coefficients at a rail", nsat);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        coef_ready = 1'b1;
        for (int n = 0; n < 64; n++) pix[n] = 8'd128;
        build_dct_lut();
        test_reset();
        test_flat_128();
        test_flat_255();
        test_impulse();
        test_backpressure();
        test_start_while_busy();
        test_reset_midblock();
        build_dct_lut();
        test_saturation_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dct_block_sequencer.md
Name: dct_block_sequencer

Overview:
Sequences the 2-D 8x8 DCT cosine-LUT datapath over one pixel block. It walks all 64 output coefficients (k1,k2) in raster order. For each coefficient it issues the 64 pixel/LUT addresses (n1,n2), multiply-accumulates the level-shifted pixels against the selected cosine term, then rounds, shifts and saturates the sum. Each result is presented on a valid/ready stream. It sits between the 64-entry pixel block buffer, the bank of per-(k1,k2) cosine LUTs, and the coefficient quantiser downstream.

Parameters:
PIX_W, 8, unsigned pixel width; the level shift subtracts 2^(PIX_W-1).
COS_W, 32, signed cosine-term width (Q.8 values from the LUT bank, including C(k1)C(k2)).
ACC_W, 32, signed accumulator width.
RESULT_SHIFT, 10, arithmetic right shift applied to the accumulator (8 fractional bits + the /4 normalisation).
COEF_W, 16, signed output coefficient width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request to transform the block currently held in the pixel buffer.
busy  out  1  high from the cycle after start is accepted until return to IDLE.
lut_k1  out  3  selects the LUT bank row index k1.
lut_k2  out  3  selects the LUT bank column index k2.
n1  out  3  pixel row address, also drives the LUT n1 input.
n2  out  3  pixel column address, also drives the LUT n2 input.
cos_term  in  COS_W  combinational LUT output for (lut_k1,lut_k2,n1,n2), same cycle.
pix_rdata  in  PIX_W  pixel buffer read data; valid one cycle after n1/n2.
coef_valid  out  1  coefficient available.
coef_ready  in  1  downstream accepts the coefficient.
coef_data  out  COEF_W  signed coefficient.
coef_k1  out  3  k1 index of coef_data.
coef_k2  out  3  k2 index of coef_data.
done  out  1  one-cycle pulse after the 64th coefficient handshake.

Behaviour:
- Reset (async, any state): state=IDLE. The k counter, n counter, accumulator and cos_q are all 0. All outputs are 0: busy, coef_valid, coef_data, coef_k1/k2, lut_k1/k2, n1/n2 and done.
- IDLE: start=1 is accepted and the block goes to MAC with k=0, n=0 and acc cleared. start is ignored in every other state.
- MAC (64 cycles, n=0..63):
  - {n1,n2}=n and {lut_k1,lut_k2}=k.
  - cos_term is registered into cos_q.
  - From the second MAC cycle onward: acc += (pix_rdata - 2^(PIX_W-1)) * cos_q. The pixel is zero-extended and made signed before the subtract; the product is truncated to ACC_W.
  - After n=63 the block goes to DRAIN.
- DRAIN (1 cycle): performs the final accumulate for n=63. It then registers coef_data = sat_COEF_W((acc + 2^(RESULT_SHIFT-1)) >>> RESULT_SHIFT) (round half up, saturating) and registers coef_k1/k2 = k. Goes to OUT.
- OUT: coef_valid=1.
  - coef_data and coef_k1/k2 are held stable, n1/n2 are held, and no accumulation occurs while coef_ready=0.
  - On handshake (coef_valid & coef_ready) with k=63: go to IDLE; done=1 next cycle; busy=0.
  - On handshake with k<63: k++, acc cleared, n=0, go to MAC.
- Coefficient order: k1 outer, k2 inner (k = {k1,k2}).
- Latency with coef_ready tied high (start accepted in cycle 0):
  - Coefficient j is valid in cycle 66+66*j.
  - The last coefficient is valid in cycle 4224.
  - done pulses in cycle 4225.
- Saturation: results above 2^(COEF_W-1)-1 clamp to the maximum; results below -2^(COEF_W-1) clamp to the minimum.
- coef_valid never drops without a handshake except on rst.

Test Plan:
- All pixels 128 (level-shifted 0), ready high -> 64 coefficients all 0, in raster order with coef_k1/k2 = 0,0 .. 7,7; first valid in cycle 66; done in cycle 4225.
- All pixels 255 -> DC coefficient (0,0) = (64*127*128+512)>>>10 = 1016; every AC coefficient = 0.
- Pixel (0,0)=255, all others 128 -> coefficient (1,3) = (127*208+512)>>>10 = 26; coefficient (7,7) is computed with the same formula.
- coef_ready held low for 5 cycles at coefficient 0 -> coef_valid, coef_data, n1/n2 all stable; accumulator unchanged; coefficient 1 valid exactly 66 cycles after the delayed handshake.
- start pulsed while busy (coefficient 3) -> ignored; sequence and values unaffected; a single done pulse.
- rst asserted during MAC of coefficient 10 -> all outputs 0 immediately (asynchronous); a new start restarts at k=(0,0) and yields correct results.
